// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: scene states, background colours, widths.
package vga_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } scene_t;

    localparam logic [11:0] BG_SKY      = 12'h0FF;
    localparam logic [11:0] BG_FLASH_HI = 12'hF00;
    localparam logic [11:0] BG_FLASH_LO = 12'h400;

    localparam int SCROLL_W = 11;

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical-blank rising-edge detector; emits one registered pulse per frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vblnk,
    output logic o_tick
);

    logic r_vblnk_d;
    logic r_tick;

    // Delay vblnk one cycle and register the rise so the pulse lands the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_d <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vblnk_d <= i_vblnk;
            r_tick    <= i_vblnk & ~r_vblnk_d;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/bg_scene_ctrl.sv
// Background scene controller: game-level FSM, background colour and
// horizontal scroll, all updated only on the per-frame tick.
module bg_scene_ctrl
    import vga_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int OVER_FRAMES  = 120,
    parameter int SCROLL_STEP  = 2,
    parameter int SCROLL_WRAP  = 800
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vblnk,
    input  logic                start,
    input  logic                collide,
    output logic [11:0]         bg_rgb,
    output logic [1:0]          state,
    output logic                frame_tick,
    output logic [SCROLL_W-1:0] scroll
);

    // Guard against degenerate 1-frame parameters giving zero-width counters.
    localparam int FW  = (OVER_FRAMES  > 1) ? $clog2(OVER_FRAMES)  : 1;
    localparam int FLW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic                w_tick;
    logic                r_start_pend;
    logic                r_collide_pend;
    logic                w_start_eff;
    logic                w_collide_eff;

    scene_t              r_state;
    scene_t              w_state_nxt;
    logic [11:0]         r_bg;
    logic [11:0]         w_bg_nxt;
    logic [SCROLL_W-1:0] r_scroll;
    logic [SCROLL_W-1:0] w_scroll_nxt;
    logic [FW-1:0]       r_frame_cnt;
    logic [FW-1:0]       w_frame_cnt_nxt;
    logic [FLW-1:0]      r_flash_cnt;
    logic [FLW-1:0]      w_flash_cnt_nxt;

    // One extra bit of headroom so the add never overflows before wrapping.
    logic [SCROLL_W:0]   w_scroll_sum;
    logic [SCROLL_W:0]   w_scroll_adv;

    frame_tick_gen u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vblnk (vblnk),
        .o_tick  (w_tick)
    );

    assign frame_tick    = w_tick;
    assign w_start_eff   = r_start_pend | start;
    assign w_collide_eff = r_collide_pend | collide;

    assign w_scroll_sum = {1'b0, r_scroll} + (SCROLL_W+1)'(SCROLL_STEP);
    assign w_scroll_adv = (w_scroll_sum >= (SCROLL_W+1)'(SCROLL_WRAP))
                        ? w_scroll_sum - (SCROLL_W+1)'(SCROLL_WRAP)
                        : w_scroll_sum;

    // Latch button/collision pulses until the next tick consumes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_pend   <= 1'b0;
            r_collide_pend <= 1'b0;
        end else if (w_tick) begin
            r_start_pend   <= 1'b0;
            r_collide_pend <= 1'b0;
        end else begin
            if (start)   r_start_pend   <= 1'b1;
            if (collide) r_collide_pend <= 1'b1;
        end
    end

    // Scene state and the registered outputs it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= TITLE;
            r_bg        <= BG_SKY;
            r_scroll    <= '0;
            r_frame_cnt <= '0;
            r_flash_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bg        <= w_bg_nxt;
            r_scroll    <= w_scroll_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_flash_cnt <= w_flash_cnt_nxt;
        end
    end

    // Next-state logic; nothing moves except on a frame tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_bg_nxt        = r_bg;
        w_scroll_nxt    = r_scroll;
        w_frame_cnt_nxt = r_frame_cnt;
        w_flash_cnt_nxt = r_flash_cnt;
        if (w_tick) begin
            case (r_state)
                TITLE: begin
                    w_bg_nxt     = BG_SKY;
                    w_scroll_nxt = '0;
                    if (w_start_eff) w_state_nxt = PLAY;
                end
                PLAY: begin
                    w_bg_nxt = BG_SKY;
                    // Collision outranks everything; scroll freezes at the crash point.
                    if (w_collide_eff) begin
                        w_state_nxt     = OVER;
                        w_bg_nxt        = BG_FLASH_HI;
                        w_frame_cnt_nxt = '0;
                        w_flash_cnt_nxt = '0;
                    end else begin
                        w_scroll_nxt = SCROLL_W'(w_scroll_adv);
                    end
                end
                OVER: begin
                    // Start presses here are dropped with the pending flags.
                    if (r_frame_cnt == FW'(OVER_FRAMES - 1)) begin
                        w_state_nxt     = TITLE;
                        w_bg_nxt        = BG_SKY;
                        w_scroll_nxt    = '0;
                        w_frame_cnt_nxt = '0;
                        w_flash_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
                        if (r_flash_cnt == FLW'(FLASH_FRAMES - 1)) begin
                            w_flash_cnt_nxt = '0;
                            w_bg_nxt = (r_bg == BG_FLASH_HI) ? BG_FLASH_LO : BG_FLASH_HI;
                        end else begin
                            w_flash_cnt_nxt = r_flash_cnt + FLW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt     = TITLE;
                    w_bg_nxt        = BG_SKY;
                    w_scroll_nxt    = '0;
                    w_frame_cnt_nxt = '0;
                    w_flash_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign bg_rgb = r_bg;
    assign state  = r_state;
    assign scroll = r_scroll;

endmodule
